// File: rtl/dlk_deserializer_if.sv
// Word handoff from the downlink deserializer to its consumer (valid/ready).
interface dlk_deserializer_if #(
   parameter int unsigned NBITS = 40
);
   logic [NBITS-1:0] word_data;
   logic             word_valid;
   logic             word_ready;

   modport master (
      output word_data,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  word_data,
      input  word_valid,
      output word_ready
   );
endinterface

// File: rtl/dlk_deserializer.sv
// AGC downlink receiver: synchronizes DKSTRT/DKBSNC/DKEND/DKDATA, rebuilds
// NBITS-bit words MSB first and offers them over a one-word valid/ready buffer.
module dlk_deserializer #(
   parameter int unsigned NBITS       = 40,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                      SIM_CLK,
   input  logic                      SIM_RST,
   input  logic                      DKSTRT,
   input  logic                      DKBSNC,
   input  logic                      DKEND,
   input  logic                      DKDATA,
   dlk_deserializer_if.master        word_if,
   output logic                      frame_err,
   output logic                      overrun,
   output logic [7:0]                err_count,
   output logic [5:0]                bit_count
);

   typedef enum logic [1:0] {StIdle, StShift, StOver} state_e;

   localparam logic [5:0] NbitsC = 6'(NBITS);

   // Vector order: {data, end, bsnc, start}; data shares the strobes' delay.
   logic [3:0]       sync_q [SYNC_STAGES];
   logic [3:0]       synced;
   logic [2:0]       prev_q;
   logic             st_e, bs_e, end_e, data_s;

   state_e           state_q, state_d;
   logic [NBITS-1:0] sr_q, sr_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [NBITS-1:0] word_data_q, word_data_d;
   logic             word_valid_q, word_valid_d;
   logic             frame_err_q, overrun_q;
   logic [7:0]       err_q, err_d;
   logic             commit, ferr, load, ovr;
   logic [8:0]       err_sum;

   assign synced = sync_q[SYNC_STAGES-1];
   assign st_e   = synced[0] & ~prev_q[0];
   assign bs_e   = synced[1] & ~prev_q[1];
   assign end_e  = synced[2] & ~prev_q[2];
   assign data_s = synced[3];

   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= {DKDATA, DKEND, DKBSNC, DKSTRT};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= synced[2:0];
      end
   end

   // Priority inside a cycle: start, then end, then bit-sync.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      ferr    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (st_e) begin
               state_d = StShift;
               sr_d    = '0;
               cnt_d   = '0;
            end
         end
         StShift: begin
            if (st_e) begin
               ferr  = 1'b1;
               sr_d  = '0;
               cnt_d = '0;
            end else if (end_e) begin
               if (cnt_q == NbitsC) commit = 1'b1;
               else                 ferr   = 1'b1;
               state_d = StIdle;
               cnt_d   = '0;
            end else if (bs_e) begin
               if (cnt_q < NbitsC) begin
                  sr_d  = {sr_q[NBITS-2:0], data_s};
                  cnt_d = cnt_q + 6'd1;
               end else begin
                  state_d = StOver;
               end
            end
         end
         StOver: begin
            if (st_e) begin
               ferr    = 1'b1;
               state_d = StShift;
               sr_d    = '0;
               cnt_d   = '0;
            end else if (end_e) begin
               ferr    = 1'b1;
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A commit may reuse the buffer slot in the same cycle it is consumed.
   assign load = commit & (~word_valid_q | word_if.word_ready);
   assign ovr  = commit & ~load;

   always_comb begin
      word_data_d  = word_data_q;
      word_valid_d = word_valid_q;
      if (load) begin
         word_data_d  = sr_q;
         word_valid_d = 1'b1;
      end else if (word_valid_q && word_if.word_ready) begin
         word_valid_d = 1'b0;
      end
   end

   assign err_sum = {1'b0, err_q} + {8'd0, ferr} + {8'd0, ovr};
   assign err_d   = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];

   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         state_q      <= StIdle;
         sr_q         <= '0;
         cnt_q        <= '0;
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         word_data_q  <= word_data_d;
         word_valid_q <= word_valid_d;
         frame_err_q  <= ferr;
         overrun_q    <= ovr;
         err_q        <= err_d;
      end
   end

   assign word_if.word_data  = word_data_q;
   assign word_if.word_valid = word_valid_q;
   assign frame_err          = frame_err_q;
   assign overrun            = overrun_q;
   assign err_count          = err_q;
   assign bit_count          = cnt_q;

endmodule

// File: tb/tb_dlk_deserializer.sv
// Directed bench for dlk_deserializer: framing, handshake, errors, saturation.
module tb_dlk_deserializer;

   logic       SIM_CLK = 1'b0;
   logic       SIM_RST = 1'b1;
   logic       DKSTRT  = 1'b0;
   logic       DKBSNC  = 1'b0;
   logic       DKEND   = 1'b0;
   logic       DKDATA  = 1'b0;
   logic       frame_err, overrun;
   logic [7:0] err_count;
   logic [5:0] bit_count;

   int n_cmp  = 0;
   int n_fail = 0;

   int          m_ferr = 0;
   int          m_ovr  = 0;
   int          m_vcyc = 0;
   int          m_acc  = 0;
   logic [39:0] m_last = '0;

   dlk_deserializer_if #(.NBITS(40)) wif ();

   dlk_deserializer #(.NBITS(40), .SYNC_STAGES(2)) dut (
      .SIM_CLK   (SIM_CLK),
      .SIM_RST   (SIM_RST),
      .DKSTRT    (DKSTRT),
      .DKBSNC    (DKBSNC),
      .DKEND     (DKEND),
      .DKDATA    (DKDATA),
      .word_if   (wif),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_count (err_count),
      .bit_count (bit_count)
   );

   always #5 SIM_CLK = ~SIM_CLK;

   // Event monitor, sampled mid-cycle.
   always @(negedge SIM_CLK) begin
      if (!SIM_RST) begin
         if (frame_err) m_ferr++;
         if (overrun) m_ovr++;
         if (wif.word_valid) m_vcyc++;
         if (wif.word_valid && wif.word_ready) begin
            m_acc++;
            m_last = wif.word_data;
         end
      end
   end

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   // sel: 0 = DKSTRT, 1 = DKBSNC, 2 = DKEND
   task automatic pulse(input int sel, input logic d);
      @(negedge SIM_CLK);
      DKDATA = d;
      if (sel == 0) DKSTRT = 1'b1;
      if (sel == 1) DKBSNC = 1'b1;
      if (sel == 2) DKEND  = 1'b1;
      repeat (3) @(negedge SIM_CLK);
      DKSTRT = 1'b0;
      DKBSNC = 1'b0;
      DKEND  = 1'b0;
      repeat (3) @(negedge SIM_CLK);
   endtask

   task automatic send_bits(input logic [39:0] w, input int n);
      for (int i = 0; i < n; i++) pulse(1, (i < 40) ? w[39-i] : 1'b0);
   endtask

   task automatic send_frame(input logic [39:0] w, input int n);
      pulse(0, 1'b0);
      send_bits(w, n);
      pulse(2, 1'b0);
      repeat (6) @(negedge SIM_CLK);
   endtask

   task automatic do_reset();
      @(negedge SIM_CLK);
      SIM_RST = 1'b1;
      DKSTRT = 1'b0; DKBSNC = 1'b0; DKEND = 1'b0; DKDATA = 1'b0;
      repeat (3) @(negedge SIM_CLK);
      SIM_RST = 1'b0;
      @(negedge SIM_CLK);
   endtask

   task automatic test_reset();
      wif.word_ready = 1'b0;
      DKSTRT = 1'b1; DKBSNC = 1'b1; DKEND = 1'b1; DKDATA = 1'b1;
      repeat (4) @(negedge SIM_CLK);
      do_reset();
      n_cmp++;
      if ({wif.word_valid, frame_err, overrun} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 000",
                  {wif.word_valid, frame_err, overrun});
      end
      n_cmp++;
      if (wif.word_data !== 40'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 0", wif.word_data);
      end
      n_cmp++;
      if ({err_count, bit_count} !== 14'h0) begin
         n_fail++;
         $display("FAIL reset_counts: got err=%0d bits=%0d required 0/0", err_count, bit_count);
      end
   endtask

   task automatic test_single_frame();
      int f0, o0, v0, a0, lat;
      do_reset();
      wif.word_ready = 1'b1;
      f0 = m_ferr; o0 = m_ovr; v0 = m_vcyc; a0 = m_acc;
      pulse(0, 1'b0);
      send_bits(40'hA512345678, 40);
      @(negedge SIM_CLK);
      DKEND = 1'b1;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge SIM_CLK);
         #1;
         if (wif.word_valid && lat == 0) lat = k;
      end
      @(negedge SIM_CLK);
      DKEND = 1'b0;
      repeat (6) @(negedge SIM_CLK);
      n_cmp++;
      if (lat !== 3) begin
         n_fail++;
         $display("FAIL single_latency: got %0d edges required 3", lat);
      end
      n_cmp++;
      if (m_acc - a0 !== 1 || m_last !== 40'hA512345678) begin
         n_fail++;
         $display("FAIL single_word: got %0d words last=%h required 1 word A512345678",
                  m_acc - a0, m_last);
      end
      n_cmp++;
      if (m_vcyc - v0 !== 1) begin
         n_fail++;
         $display("FAIL single_valid_len: got %0d cycles required 1", m_vcyc - v0);
      end
      n_cmp++;
      if (m_ferr - f0 !== 0 || m_ovr - o0 !== 0 || err_count !== 8'd0) begin
         n_fail++;
         $display("FAIL single_noerr: got ferr=%0d ovr=%0d err=%0d required 0/0/0",
                  m_ferr - f0, m_ovr - o0, err_count);
      end
   endtask

   task automatic test_overrun();
      int o0, a0;
      do_reset();
      wif.word_ready = 1'b0;
      o0 = m_ovr; a0 = m_acc;
      send_frame(40'hDEADBEEF01, 40);
      n_cmp++;
      if (wif.word_valid !== 1'b1 || wif.word_data !== 40'hDEADBEEF01) begin
         n_fail++;
         $display("FAIL ovr_first: got valid=%b data=%h required 1 DEADBEEF01",
                  wif.word_valid, wif.word_data);
      end
      send_frame(40'h0123456789, 40);
      n_cmp++;
      if (m_ovr - o0 !== 1 || err_count !== 8'd1) begin
         n_fail++;
         $display("FAIL ovr_pulse: got ovr=%0d err=%0d required 1/1", m_ovr - o0, err_count);
      end
      n_cmp++;
      if (wif.word_data !== 40'hDEADBEEF01) begin
         n_fail++;
         $display("FAIL ovr_held: got %h required DEADBEEF01", wif.word_data);
      end
      @(negedge SIM_CLK);
      wif.word_ready = 1'b1;
      repeat (2) @(negedge SIM_CLK);
      n_cmp++;
      if (wif.word_valid !== 1'b0 || m_acc - a0 !== 1 || m_last !== 40'hDEADBEEF01) begin
         n_fail++;
         $display("FAIL ovr_drain: got valid=%b acc=%0d last=%h required 0 1 DEADBEEF01",
                  wif.word_valid, m_acc - a0, m_last);
      end
   endtask

   task automatic test_bad_length();
      int f0, a0;
      do_reset();
      wif.word_ready = 1'b1;
      f0 = m_ferr; a0 = m_acc;
      pulse(0, 1'b0);
      send_bits(40'hFFFFFFFFFF, 39);
      n_cmp++;
      if (bit_count !== 6'd39) begin
         n_fail++;
         $display("FAIL short_bitcount: got %0d required 39", bit_count);
      end
      pulse(2, 1'b0);
      repeat (6) @(negedge SIM_CLK);
      n_cmp++;
      if (m_ferr - f0 !== 1 || m_acc - a0 !== 0 || err_count !== 8'd1 || wif.word_valid !== 1'b0)
      begin
         n_fail++;
         $display("FAIL short_frame: got ferr=%0d words=%0d err=%0d valid=%b required 1/0/1/0",
                  m_ferr - f0, m_acc - a0, err_count, wif.word_valid);
      end
      send_frame(40'h5555555555, 41);
      n_cmp++;
      if (m_ferr - f0 !== 2 || m_acc - a0 !== 0 || err_count !== 8'd2 || bit_count !== 6'd0) begin
         n_fail++;
         $display("FAIL long_frame: got ferr=%0d words=%0d err=%0d bits=%0d required 2/0/2/0",
                  m_ferr - f0, m_acc - a0, err_count, bit_count);
      end
   endtask

   task automatic test_restart();
      int f0, a0;
      do_reset();
      wif.word_ready = 1'b1;
      f0 = m_ferr; a0 = m_acc;
      pulse(0, 1'b0);
      send_bits(40'hFFFFFFFFFF, 20);
      send_frame(40'h3C_0F0F_A5C3, 40);
      n_cmp++;
      if (m_ferr - f0 !== 1 || err_count !== 8'd1) begin
         n_fail++;
         $display("FAIL restart_err: got ferr=%0d err=%0d required 1/1", m_ferr - f0, err_count);
      end
      n_cmp++;
      if (m_acc - a0 !== 1 || m_last !== 40'h3C0F0FA5C3) begin
         n_fail++;
         $display("FAIL restart_word: got %0d words last=%h required 1 3C0F0FA5C3",
                  m_acc - a0, m_last);
      end
   endtask

   task automatic test_reset_midframe();
      int f0, o0, a0;
      do_reset();
      wif.word_ready = 1'b1;
      pulse(0, 1'b0);
      send_bits(40'hFFFFFFFFFF, 25);
      do_reset();
      f0 = m_ferr; o0 = m_ovr; a0 = m_acc;
      n_cmp++;
      if (bit_count !== 6'd0) begin
         n_fail++;
         $display("FAIL rst_mid_bitcount: got %0d required 0", bit_count);
      end
      // Without a fresh DKSTRT nothing may be assembled.
      send_bits(40'h1122334455, 40);
      pulse(2, 1'b0);
      repeat (6) @(negedge SIM_CLK);
      n_cmp++;
      if (m_acc - a0 !== 0 || m_ferr - f0 !== 0) begin
         n_fail++;
         $display("FAIL rst_mid_nostart: got words=%0d ferr=%0d required 0/0",
                  m_acc - a0, m_ferr - f0);
      end
      send_frame(40'h9876543210, 40);
      n_cmp++;
      if (m_acc - a0 !== 1 || m_last !== 40'h9876543210) begin
         n_fail++;
         $display("FAIL rst_mid_word: got %0d words last=%h required 1 9876543210",
                  m_acc - a0, m_last);
      end
      n_cmp++;
      if (m_ferr - f0 !== 0 || m_ovr - o0 !== 0 || err_count !== 8'd0) begin
         n_fail++;
         $display("FAIL rst_mid_noerr: got ferr=%0d ovr=%0d err=%0d required 0/0/0",
                  m_ferr - f0, m_ovr - o0, err_count);
      end
   endtask

   task automatic test_saturate_and_stray();
      int f0, o0;
      do_reset();
      wif.word_ready = 1'b1;
      f0 = m_ferr;
      for (int i = 0; i < 300; i++) begin
         pulse(0, 1'b0);
         pulse(2, 1'b0);
      end
      repeat (6) @(negedge SIM_CLK);
      n_cmp++;
      if (err_count !== 8'd255 || m_ferr - f0 !== 300) begin
         n_fail++;
         $display("FAIL saturate: got err=%0d ferr=%0d required 255/300", err_count, m_ferr - f0);
      end
      wif.word_ready = 1'b0;
      send_frame(40'hC0FFEE1234, 40);
      f0 = m_ferr; o0 = m_ovr;
      pulse(1, 1'b1);
      pulse(2, 1'b0);
      pulse(1, 1'b0);
      repeat (6) @(negedge SIM_CLK);
      n_cmp++;
      if (wif.word_valid !== 1'b1 || wif.word_data !== 40'hC0FFEE1234) begin
         n_fail++;
         $display("FAIL stray_word: got valid=%b data=%h required 1 C0FFEE1234",
                  wif.word_valid, wif.word_data);
      end
      n_cmp++;
      if (m_ferr - f0 !== 0 || m_ovr - o0 !== 0 || err_count !== 8'd255 || bit_count !== 6'd0)
      begin
         n_fail++;
         $display("FAIL stray_idle: got ferr=%0d ovr=%0d err=%0d bits=%0d required 0/0/255/0",
                  m_ferr - f0, m_ovr - o0, err_count, bit_count);
      end
   endtask

   initial begin
      wif.word_ready = 1'b0;
      test_reset();
      test_single_frame();
      test_overrun();
      test_bad_length();
      test_restart();
      test_reset_midframe();
      test_saturate_and_stray();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
